// File: rtl/fft_pkg.sv
// fft_pkg: shared defaults, loader state encoding and address bit-reversal helper.
package fft_pkg;
    localparam int DEFAULT_BIT_WIDTH = 16;
    localparam int DEFAULT_N         = 9;
    localparam int DEFAULT_FFT_SIZE  = 2 ** DEFAULT_N;

    typedef enum logic [1:0] {IDLE, COLLECT, START, WAIT} loader_state_t;

    function automatic logic [31:0] bitrev(input logic [31:0] x, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++)
            if (i < w) r[5'(i)] = x[5'(w - 1 - i)];
        return r;
    endfunction
endpackage

// File: rtl/fft_frame_loader_if.sv
// fft_frame_loader_if: sample-in / FFT-buffer-load bundle between front end, loader and FFT core.
interface fft_frame_loader_if #(
    parameter int BIT_WIDTH = fft_pkg::DEFAULT_BIT_WIDTH,
    parameter int N         = fft_pkg::DEFAULT_N
);
    logic                        capture_en;
    logic                        sample_valid;
    logic signed [BIT_WIDTH-1:0] sample_in;
    logic                        fft_done;
    logic                        fft_load;
    logic signed [BIT_WIDTH-1:0] din;
    logic [N-1:0]                add_wr;
    logic                        fft_start;
    logic                        busy;
    logic                        frame_done;
    logic                        overrun;

    modport master (
        input  capture_en, sample_valid, sample_in, fft_done,
        output fft_load, din, add_wr, fft_start, busy, frame_done, overrun
    );
    modport slave (
        output capture_en, sample_valid, sample_in, fft_done,
        input  fft_load, din, add_wr, fft_start, busy, frame_done, overrun
    );
endinterface

// File: rtl/fft_frame_loader_sample_decimator.sv
// sample_decimator: passes every DECIM-th valid strobe as keep; counter held at 0 while clr.
module sample_decimator #(
    parameter int DECIM = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic valid,
    output logic keep
);
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        keep  = valid && cnt_q == 8'(DECIM - 1);
        cnt_d = clr ? '0 : !valid ? cnt_q : keep ? '0 : cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/fft_frame_loader.sv
// fft_frame_loader: fills the FFT buffer with one frame of kept samples, starts the FFT, awaits done.
// Define FFT_BITREV_LOAD_EN to write samples at bit-reversed addresses (DIT input ordering).
module fft_frame_loader import fft_pkg::*; #(
    parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH,
    parameter int N         = DEFAULT_N,
    parameter int FFT_SIZE  = 2 ** N,
    parameter int DECIM     = 1
) (
    input logic               clk,
    input logic               reset,
    fft_frame_loader_if.master bus
);
    loader_state_t               state_q, state_d;
    logic [N-1:0]                idx_q, idx_d, addr_q, addr_d, addr_idx;
    logic signed [BIT_WIDTH-1:0] din_q, din_d;
    logic                        load_q, load_d, start_q, start_d;
    logic                        frame_done_q, frame_done_d, overrun_q, overrun_d;
    logic                        done_q, keep, store, rise, busy;

    sample_decimator #(.DECIM(DECIM)) u_decim (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q == IDLE),
        .valid (bus.sample_valid && state_q != IDLE),
        .keep  (keep)
    );

`ifdef FFT_BITREV_LOAD_EN
    assign addr_idx = N'(bitrev(32'(idx_q), N));
`else
    assign addr_idx = idx_q;
`endif

    always_comb begin
        state_d = state_q;
        busy    = state_q == START || state_q == WAIT;
        store   = state_q == COLLECT && bus.capture_en && keep;
        // done_q tracks fft_done in every state, so a level left high by the last frame is no edge
        rise    = bus.fft_done && !done_q;
        case (state_q)
            IDLE:    if (bus.capture_en) state_d = COLLECT;
            COLLECT: state_d = !bus.capture_en ? IDLE
                             : (store && idx_q == N'(FFT_SIZE - 1)) ? START : COLLECT;
            START:   state_d = WAIT;
            WAIT:    if (rise) state_d = bus.capture_en ? COLLECT : IDLE;
            default: state_d = IDLE;
        endcase
        idx_d        = store ? idx_q + N'(1) : state_q == IDLE ? '0 : idx_q;
        load_d       = store;
        din_d        = store ? bus.sample_in : din_q;
        addr_d       = store ? addr_idx : addr_q;
        start_d      = state_q == START;
        frame_done_d = state_q == WAIT && rise;
        overrun_d    = state_d == IDLE ? 1'b0 : (busy && keep) ? 1'b1 : overrun_q;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            load_q       <= 1'b0;
            din_q        <= '0;
            addr_q       <= '0;
            start_q      <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            load_q       <= load_d;
            din_q        <= din_d;
            addr_q       <= addr_d;
            start_q      <= start_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            done_q       <= bus.fft_done;
        end

    assign bus.fft_load   = load_q;
    assign bus.din        = din_q;
    assign bus.add_wr     = addr_q;
    assign bus.fft_start  = start_q;
    assign bus.busy       = busy;
    assign bus.frame_done = frame_done_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_fft_frame_loader.sv
// tb_fft_frame_loader: directed checks of frame load, handshake, overrun, decimation, abort, addressing.
module tb_fft_frame_loader;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   nloads;

`ifdef FFT_BITREV_LOAD_EN
    localparam int A1 = 256;
    localparam int A3 = 384;
`else
    localparam int A1 = 1;
    localparam int A3 = 3;
`endif

    fft_frame_loader_if #(.BIT_WIDTH(16), .N(9)) ia ();
    fft_frame_loader_if #(.BIT_WIDTH(16), .N(9)) ib ();

    fft_frame_loader #(.BIT_WIDTH(16), .N(9), .FFT_SIZE(512), .DECIM(1)) u_a (
        .clk(clk), .reset(reset), .bus(ia));
    fft_frame_loader #(.BIT_WIDTH(16), .N(9), .FFT_SIZE(512), .DECIM(4)) u_b (
        .clk(clk), .reset(reset), .bus(ib));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int exp_addr(input int i);
`ifdef FFT_BITREV_LOAD_EN
        int r = 0;
        for (int b = 0; b < 9; b++) if (i[b]) r = r | (1 << (8 - b));
        return r;
`else
        return i;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input int n);
        for (int i = 0; i < n; i++) begin
            ia.sample_valid = 1'b1;
            ia.sample_in    = 16'(i);
            tick();
            check("load_nostart", 32'({ia.fft_load, ia.fft_start}), 32'b10);
            check("add_wr", 32'(ia.add_wr), 32'(exp_addr(i)));
            check("din", 32'(ia.din), 32'(i));
        end
        ia.sample_valid = 1'b0;
    endtask

    initial begin
        {ia.capture_en, ia.sample_valid, ia.fft_done} = '0;
        {ib.capture_en, ib.sample_valid, ib.fft_done} = '0;
        ia.sample_in = '0;
        ib.sample_in = '0;
        repeat (2) tick();
        check("rst_flags", 32'({ia.fft_load, ia.fft_start, ia.busy, ia.frame_done, ia.overrun}), 32'd0);
        check("rst_addr", 32'(ia.add_wr), 32'd0);

        // reset mid-COLLECT at index 100
        reset = 1'b1;
        ia.capture_en = 1'b1;
        tick();
        for (int i = 0; i <= 100; i++) begin
            ia.sample_valid = 1'b1;
            ia.sample_in    = 16'(i + 1000);
            tick();
        end
        ia.sample_valid = 1'b0;
        check("pre_rst_load", 32'(ia.fft_load), 32'd1);
        check("pre_rst_addr", 32'(ia.add_wr), 32'(exp_addr(100)));
        #2 reset = 1'b0;
        #1;
        check("async_rst_flags", 32'({ia.fft_load, ia.fft_start, ia.busy, ia.frame_done, ia.overrun}), 32'd0);
        check("async_rst_addr", 32'(ia.add_wr), 32'd0);
        check("async_rst_din", 32'(ia.din), 32'd0);
        tick();
        reset = 1'b1;
        ia.fft_done = 1'b1;
        tick();

        // frame 1 with fft_done already high (stale)
        send_frame(512);
        tick();
        check("start_pulse", 32'({ia.fft_start, ia.fft_load, ia.busy}), 32'b101);
        tick();
        check("start_one_cycle", 32'({ia.fft_start, ia.busy}), 32'b01);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stale_done_no_exit", 32'({ia.frame_done, ia.busy}), 32'b01);
        end
        ia.fft_done = 1'b0;
        repeat (20) tick();
        check("wait_busy", 32'({ia.frame_done, ia.busy}), 32'b01);
        ia.fft_done = 1'b1;
        tick();
        check("frame_done_pulse", 32'({ia.frame_done, ia.busy}), 32'b10);
        tick();
        check("frame_done_once", 32'(ia.frame_done), 32'd0);

        // frame 2 restarts at address 0, then overrun in WAIT
        send_frame(512);
        tick();
        check("start2", 32'(ia.fft_start), 32'd1);
        for (int i = 0; i < 3; i++) begin
            ia.sample_valid = 1'b1;
            ia.sample_in    = 16'h7777;
            tick();
            check("drop_in_wait", 32'(ia.fft_load), 32'd0);
        end
        ia.sample_valid = 1'b0;
        tick();
        check("overrun_set", 32'({ia.overrun, ia.busy}), 32'b11);
        ia.capture_en = 1'b0;
        repeat (3) tick();
        check("overrun_hold", 32'({ia.overrun, ia.busy}), 32'b11);
        ia.fft_done = 1'b0;
        tick();
        ia.fft_done = 1'b1;
        tick();
        check("done_to_idle", 32'({ia.frame_done, ia.busy, ia.overrun}), 32'b100);
        ia.sample_valid = 1'b1;
        tick();
        check("idle_no_load", 32'({ia.fft_load, ia.overrun}), 32'b00);
        ia.sample_valid = 1'b0;

        // abort at index 37
        ia.capture_en = 1'b1;
        tick();
        send_frame(37);
        ia.capture_en   = 1'b0;
        ia.sample_valid = 1'b1;
        ia.sample_in    = 16'd37;
        tick();
        check("abort_discard", 32'(ia.fft_load), 32'd0);
        ia.sample_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort_no_start", 32'({ia.fft_start, ia.busy}), 32'b00);
        end
        ia.capture_en = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            ia.sample_valid = 1'b1;
            ia.sample_in    = 16'(i);
            tick();
            check("rearm_load", 32'(ia.fft_load), 32'd1);
            if (i == 0) check("rearm_addr0", 32'(ia.add_wr), 32'd0);
            if (i == 1) check("addr_idx1", 32'(ia.add_wr), 32'(A1));
            if (i == 3) check("addr_idx3", 32'(ia.add_wr), 32'(A3));
        end
        ia.sample_valid = 1'b0;
        ia.capture_en   = 1'b0;
        tick();

        // decimation by 4 on the second instance
        ib.capture_en = 1'b1;
        tick();
        nloads = 0;
        for (int s = 1; s <= 2048; s++) begin
            ib.sample_valid = 1'b1;
            ib.sample_in    = 16'(s);
            tick();
            check("decim_load", 32'(ib.fft_load), 32'(s % 4 == 0));
            if (ib.fft_load) nloads++;
            if (s % 4 == 0) begin
                check("decim_addr", 32'(ib.add_wr), 32'(exp_addr(s / 4 - 1)));
                check("decim_din", 32'(ib.din), 32'(s));
            end
        end
        ib.sample_valid = 1'b0;
        check("decim_count", 32'(nloads), 32'd512);
        tick();
        check("decim_start", 32'({ib.fft_start, ib.busy}), 32'b11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
